prog_loader: RTL and testbench

- Byte-stream program loader: writes the CPU instruction RAM, which the CPU only reads.
- Receives a framed image over a valid/ready byte interface, assembles little-endian 32-bit words and issues single-cycle RAM writes.
- Holds the CPU in reset until a complete image with a correct checksum has been written.
- Sits between the host link (UART receiver or test bench) and the instruction RAM write port plus the CPU rst_n.

---
 rtl/prog_loader_pkg.sv | 23 ++
 rtl/prog_loader_if.sv | 24 ++
 rtl/prog_loader_word_assembler.sv | 34 +++
 rtl/prog_loader.sv | 98 +++++++++
 tb/tb_prog_loader.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared types and frame constants for the program loader
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CHK,
        DONE,
        ERR
    } loader_state_t;

    localparam logic [7:0] SYNC_DEFAULT   = 8'hA5;
    localparam int         LEN_W          = 16;
    localparam int         WORD_W         = 32;
    localparam int         BYTES_PER_WORD = 4;

    function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - host byte stream, instruction RAM write port and CPU reset bundle
interface prog_loader_if #(
    parameter int ADDR_W = 12
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst_n;
    logic              done;
    logic              error;

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, done, error
    );

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, done, error
    );
endinterface

// File: rtl/prog_loader_word_assembler.sv
// rtl/prog_loader_word_assembler.sv - packs little-endian bytes into 32-bit words
module word_assembler
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [7:0]        byte_data,
    input  logic              byte_stb,
    output logic              byte_last,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);
    logic [1:0] cnt;

    assign byte_last = (cnt == 2'(BYTES_PER_WORD - 1));

    // Bytes enter at the top so the first byte ends up in bits 7:0 after four shifts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_stb && byte_last && !clr;
            if (clr) begin
                cnt <= '0;
            end else if (byte_stb) begin
                word <= {byte_data, word[WORD_W-1:8]};
                cnt  <= cnt + 2'd1;
            end
        end
    end
endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader for the CPU instruction RAM
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         ADDR_W = 12,
    parameter logic [7:0] SYNC   = SYNC_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    prog_loader_if.slave   bus
);
    localparam int             CW    = LEN_W + 1;
    localparam logic [CW-1:0]  DEPTH = CW'(1) << ADDR_W;

    loader_state_t      state, state_nxt;
    logic               rdy_q;
    logic [7:0]         len_lo;
    logic [LEN_W-1:0]   len;
    logic [7:0]         sum;
    logic [ADDR_W-1:0]  word_idx;

    logic               accept;
    logic               sync_hit;
    logic [LEN_W-1:0]   len_in;
    logic               last_word;
    logic               byte_last;
    logic               asm_valid;
    logic [WORD_W-1:0]  asm_word;

    assign accept   = bus.rx_valid && rdy_q;
    assign sync_hit = accept && (bus.rx_data == SYNC)
                      && (state == IDLE || state == DONE || state == ERR);
    assign len_in   = {bus.rx_data, len_lo};
    // Compared one bit wider so a full-depth image does not wrap the index test.
    assign last_word = (CW'(word_idx) + CW'(1)) == CW'(len);

    word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (sync_hit),
        .byte_data  (bus.rx_data),
        .byte_stb   (accept && state == DATA),
        .byte_last  (byte_last),
        .word       (asm_word),
        .word_valid (asm_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rdy_q    <= 1'b0;
            len_lo   <= '0;
            len      <= '0;
            sum      <= '0;
            word_idx <= '0;
        end else begin
            state <= state_nxt;
            rdy_q <= 1'b1;
            if (accept && state == LEN0) len_lo <= bus.rx_data;
            if (accept && state == LEN1) len    <= len_in;
            if (sync_hit)
                sum <= '0;
            else if (accept && (state == LEN0 || state == LEN1 || state == DATA))
                sum <= chk_add(sum, bus.rx_data);
            // The index advances on the write cycle itself, so the last word keeps its address.
            if (sync_hit)
                word_idx <= '0;
            else if (asm_valid)
                word_idx <= word_idx + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: if (sync_hit) state_nxt = LEN0;
            LEN0:            if (accept) state_nxt = LEN1;
            LEN1: begin
                if (accept) begin
                    if ({1'b0, len_in} > DEPTH)  state_nxt = ERR;
                    else if (len_in == '0)       state_nxt = CHK;
                    else                         state_nxt = DATA;
                end
            end
            DATA:            if (accept && byte_last && last_word) state_nxt = CHK;
            CHK:             if (accept) state_nxt = (bus.rx_data == sum) ? DONE : ERR;
            default:         state_nxt = IDLE;
        endcase
    end

    assign bus.rx_ready  = rdy_q;
    assign bus.mem_we    = asm_valid;
    assign bus.mem_addr  = word_idx;
    assign bus.mem_wdata = asm_word;
    assign bus.cpu_rst_n = (state == DONE);
    assign bus.done      = (state == DONE);
    assign bus.error     = (state == ERR);
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader against a frame-level model
module tb_prog_loader;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst_n;

    prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0]       tx_words [0:DEPTH-1];
    logic [31:0]       exp_ram  [0:DEPTH-1];
    logic [31:0]       dut_ram  [0:DEPTH-1];
    logic [ADDR_W-1:0] got_addr [$];
    logic [31:0]       got_data [$];
    int                base;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            got_addr.push_back(bus.mem_addr);
            got_data.push_back(bus.mem_wdata);
            dut_ram[bus.mem_addr] = bus.mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                bus.rx_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    // Everything after SYNC; the model RAM records the words the frame must write.
    task automatic send_body(input int len, input logic [7:0] chk_delta, input bit gaps);
        logic [15:0] l;
        logic [7:0]  s;
        logic [31:0] w;
        l    = 16'(len);
        s    = l[7:0] + l[15:8];
        base = got_addr.size();
        send_byte(l[7:0], gaps);
        send_byte(l[15:8], gaps);
        for (int i = 0; i < len; i++) begin
            w = tx_words[i];
            exp_ram[i] = w;
            for (int b = 0; b < 4; b++) begin
                send_byte(w[8*b +: 8], gaps);
                s = s + w[8*b +: 8];
            end
        end
        send_byte(s + chk_delta, gaps);
    endtask

    task automatic send_frame(input int len, input logic [7:0] chk_delta, input bit gaps);
        send_byte(8'hA5, gaps);
        send_body(len, chk_delta, gaps);
    endtask

    task automatic check_frame(input string tag, input int len, input bit good);
        int mism;
        mism = 0;
        check({tag, ".done"},      32'(bus.done),      32'(good));
        check({tag, ".error"},     32'(bus.error),     32'(!good));
        check({tag, ".cpu_rst_n"}, 32'(bus.cpu_rst_n), 32'(good));
        check({tag, ".writes"},    32'(got_addr.size() - base), 32'(len));
        for (int i = 0; i < len && base + i < got_addr.size(); i++) begin
            if (got_addr[base+i] !== ADDR_W'(i) || got_data[base+i] !== tx_words[i])
                mism++;
        end
        check({tag, ".data_mism"}, 32'(mism), 32'd0);
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i < len; i++) tx_words[i] = $urandom;
    endtask

    initial begin
        int len;
        int mism;
        logic [7:0] delta;

        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst.rx_ready",  32'(bus.rx_ready),  32'd0);
        check("rst.mem_we",    32'(bus.mem_we),    32'd0);
        check("rst.mem_addr",  32'(bus.mem_addr),  32'd0);
        check("rst.mem_wdata", bus.mem_wdata,      32'd0);
        check("rst.cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
        check("rst.done",      32'(bus.done),      32'd0);
        check("rst.error",     32'(bus.error),     32'd0);

        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rdy.after_reset", 32'(bus.rx_ready), 32'd1);

        // Leading junk in IDLE, then the two-instruction image
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        tx_words[0] = 32'h0000_0013;
        tx_words[1] = 32'h0010_0093;
        send_frame(2, 8'h00, 1'b0);
        check_frame("f1", 2, 1'b1);
        check("f1.ram0", dut_ram[0], 32'h0000_0013);
        check("f1.ram1", dut_ram[1], 32'h0010_0093);

        send_frame(2, 8'h01, 1'b0);
        check_frame("f2_badchk", 2, 1'b0);

        send_frame(0, 8'h00, 1'b0);
        check_frame("len0_ok", 0, 1'b1);
        send_frame(0, 8'h01, 1'b0);
        check_frame("len0_bad", 0, 1'b0);

        // Oversized length fails immediately after LEN_HI
        base = got_addr.size();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h10, 1'b0);
        check("len1001.error",     32'(bus.error),     32'd1);
        check("len1001.cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("len1001.writes", 32'(got_addr.size() - base), 32'd0);

        len = $urandom_range(1, 8);
        fill_random(len);
        send_frame(len, 8'h00, 1'b1);
        check_frame("rnd_pre_resync", len, 1'b1);

        // SYNC from DONE drops the CPU back into reset on the next cycle
        send_byte(8'hA5, 1'b0);
        check("resync.cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
        check("resync.done",      32'(bus.done),      32'd0);
        tx_words[0] = 32'hDEAD_BEEF;
        send_body(1, 8'h00, 1'b0);
        check_frame("resync", 1, 1'b1);
        check("resync.ram0", dut_ram[0], 32'hDEAD_BEEF);

        for (int f = 0; f < 6; f++) begin
            len   = $urandom_range(1, 12);
            delta = ($urandom_range(0, 2) == 0) ? 8'(1 + $urandom_range(0, 254)) : 8'h00;
            fill_random(len);
            send_frame(len, delta, 1'b1);
            check_frame($sformatf("rnd%0d", f), len, delta == 8'h00);
        end

        fill_random(DEPTH);
        send_frame(DEPTH, 8'h00, 1'b0);
        check_frame("full", DEPTH, 1'b1);
        check("full.last_addr", 32'(got_addr[got_addr.size()-1]), 32'(DEPTH - 1));

        // Reset two bytes into word 0, with a SYNC presented during reset
        base = got_addr.size();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h00, 1'b0);
        rst_n        = 1'b0;
        bus.rx_data  = 8'hA5;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        check("midrst.rx_ready",  32'(bus.rx_ready),  32'd0);
        check("midrst.mem_we",    32'(bus.mem_we),    32'd0);
        check("midrst.mem_addr",  32'(bus.mem_addr),  32'd0);
        check("midrst.mem_wdata", bus.mem_wdata,      32'd0);
        check("midrst.cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
        check("midrst.done",      32'(bus.done),      32'd0);
        check("midrst.error",     32'(bus.error),     32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst.writes", 32'(got_addr.size() - base), 32'd0);
        len = 3;
        fill_random(len);
        send_frame(len, 8'h00, 1'b1);
        check_frame("post_rst", len, 1'b1);

        mism = 0;
        for (int i = 0; i < DEPTH; i++)
            if (dut_ram[i] !== exp_ram[i]) mism++;
        check("ram.final_mism", 32'(mism), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
